// File: rtl/qrs_pkg.sv
// Shared definitions for the QRS threshold controller.
//   qrs_state_t : detection FSM states
//   DEF_*       : default widths and lengths used by the top and the mean filter
package qrs_pkg;

    typedef enum logic [1:0] {
        LEARN  = 2'd0,
        DETECT = 2'd1,
        SEARCH = 2'd2,
        REFRAC = 2'd3
    } qrs_state_t;

    localparam int DEF_W          = 16;
    localparam int DEF_AVG_LOG2   = 3;
    localparam int DEF_LEARN_LEN  = 256;
    localparam int DEF_SEARCH_LEN = 16;
    localparam int DEF_REFRAC_LEN = 50;
    localparam int DEF_RR_W       = 12;

endpackage

// File: rtl/qrs_moving_avg.sv
// Windowed mean over the last 2**AVG_LOG2 sample strobes.
// Ports:
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset, clears window, sum and mpavg
//   sample_valid : one-cycle strobe; only strobes shift the window
//   sample       : W-bit unsigned sample
//   mpavg        : registered mean, zero-extended to 32 bits, valid 1 cycle after the strobe
module qrs_moving_avg
    import qrs_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_valid,
    input  logic [W-1:0] sample,
    output logic [31:0]  mpavg
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = W + AVG_LOG2;

    logic [W-1:0]     win_reg [DEPTH];
    logic [SUM_W-1:0] sum_reg;
    logic [SUM_W-1:0] sum_next;
    logic [31:0]      mpavg_reg;

    // Window slots: slot 0 takes the new sample, the last slot is the oldest.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst_n)
                        win_reg[gi] <= '0;
                    else if (sample_valid)
                        win_reg[gi] <= sample;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst_n)
                        win_reg[gi] <= '0;
                    else if (sample_valid)
                        win_reg[gi] <= win_reg[gi-1];
                end
            end
        end
    endgenerate

    // The sum always covers exactly the window contents, so it never drops
    // below the oldest sample and SUM_W bits cannot overflow.
    assign sum_next = sum_reg + SUM_W'(sample) - SUM_W'(win_reg[DEPTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg   <= '0;
            mpavg_reg <= '0;
        end else if (sample_valid) begin
            sum_reg   <= sum_next;
            mpavg_reg <= 32'(sum_next[SUM_W-1:AVG_LOG2]);
        end
    end

    assign mpavg = mpavg_reg;

endmodule

// File: rtl/qrs_threshold_controller.sv
// Sequencer for the adaptive QRS threshold datapath.
// Builds the 4-deep peak history and the windowed mean for an external
// comparator, then runs learn / detect / peak-search / refractory on its
// decision and reports one pulse per beat with peak and RR interval.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   sample_valid       : sample strobe; the only thing that advances state
//   sample             : rectified wavelet-detail magnitude
//   thr_out            : comparator decision, sampled on strobe cycles only
//   vt1..vt4           : peak history, vt1 newest
//   mpavg              : windowed mean, zero-extended
//   learning           : high while in LEARN
//   qrs_valid          : one-cycle beat pulse
//   qrs_peak           : beat peak, held between pulses
//   rr_interval        : strobes between beats, saturating, held between pulses
module qrs_threshold_controller
    import qrs_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int AVG_LOG2   = DEF_AVG_LOG2,
    parameter int LEARN_LEN  = DEF_LEARN_LEN,
    parameter int SEARCH_LEN = DEF_SEARCH_LEN,
    parameter int REFRAC_LEN = DEF_REFRAC_LEN,
    parameter int RR_W       = DEF_RR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sample_valid,
    input  logic [W-1:0]    sample,
    input  logic            thr_out,
    output logic [W-1:0]    vt1,
    output logic [W-1:0]    vt2,
    output logic [W-1:0]    vt3,
    output logic [W-1:0]    vt4,
    output logic [31:0]     mpavg,
    output logic            learning,
    output logic            qrs_valid,
    output logic [W-1:0]    qrs_peak,
    output logic [RR_W-1:0] rr_interval
);

    localparam int SEG_W  = $clog2(LEARN_LEN + 1);
    localparam int SRCH_W = $clog2(SEARCH_LEN + 1);
    localparam int REF_W  = $clog2(REFRAC_LEN + 1);
    localparam logic [RR_W-1:0] RR_MAX = {RR_W{1'b1}};

    qrs_state_t       state_reg, state_next;
    logic [SEG_W-1:0] seg_cnt_reg, seg_cnt_next;
    logic [W-1:0]     seg_max_reg, seg_max_next;
    logic [1:0]       push_cnt_reg, push_cnt_next;
    logic [RR_W-1:0]  rr_cnt_reg, rr_cnt_next;
    logic [SRCH_W-1:0] srch_cnt_reg, srch_cnt_next;
    logic [REF_W-1:0] ref_cnt_reg, ref_cnt_next;
    logic [W-1:0]     peak_reg, peak_next;
    logic             qrs_valid_reg, qrs_valid_next;
    logic [W-1:0]     qrs_peak_reg, qrs_peak_next;
    logic [RR_W-1:0]  rr_int_reg, rr_int_next;

    logic             push;
    logic [W-1:0]     push_val;
    logic [W-1:0]     vt_reg [4];

    logic [RR_W-1:0]  rr_inc;
    logic [W-1:0]     peak_max;
    logic [W-1:0]     seg_cand;

    qrs_moving_avg #(
        .W        (W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .mpavg        (mpavg)
    );

    assign rr_inc   = (rr_cnt_reg == RR_MAX) ? RR_MAX : rr_cnt_reg + 1'b1;
    assign peak_max = (sample > peak_reg)    ? sample : peak_reg;
    assign seg_cand = (sample > seg_max_reg) ? sample : seg_max_reg;

    always_comb begin
        state_next     = state_reg;
        seg_cnt_next   = seg_cnt_reg;
        seg_max_next   = seg_max_reg;
        push_cnt_next  = push_cnt_reg;
        rr_cnt_next    = rr_cnt_reg;
        srch_cnt_next  = srch_cnt_reg;
        ref_cnt_next   = ref_cnt_reg;
        peak_next      = peak_reg;
        qrs_valid_next = 1'b0;
        qrs_peak_next  = qrs_peak_reg;
        rr_int_next    = rr_int_reg;
        push           = 1'b0;
        push_val       = '0;

        if (sample_valid) begin
            case (state_reg)
                LEARN: begin
                    if (seg_cnt_reg == SEG_W'(LEARN_LEN - 1)) begin
                        push          = 1'b1;
                        push_val      = seg_cand;
                        seg_max_next  = '0;
                        seg_cnt_next  = '0;
                        push_cnt_next = push_cnt_reg + 1'b1;
                        if (push_cnt_reg == 2'd3) begin
                            state_next  = DETECT;
                            rr_cnt_next = '0;
                        end
                    end else begin
                        seg_max_next = seg_cand;
                        seg_cnt_next = seg_cnt_reg + 1'b1;
                    end
                end
                DETECT: begin
                    rr_cnt_next = rr_inc;
                    if (thr_out) begin
                        state_next    = SEARCH;
                        peak_next     = sample;
                        srch_cnt_next = SRCH_W'(1);
                    end else if (rr_inc == RR_MAX) begin
                        // No beat for the full RR range: thresholds are stale, relearn.
                        state_next    = LEARN;
                        seg_cnt_next  = '0;
                        seg_max_next  = '0;
                        push_cnt_next = '0;
                    end
                end
                SEARCH: begin
                    rr_cnt_next   = rr_inc;
                    peak_next     = peak_max;
                    srch_cnt_next = srch_cnt_reg + 1'b1;
                    if (srch_cnt_reg == SRCH_W'(SEARCH_LEN - 1)) begin
                        qrs_valid_next = 1'b1;
                        qrs_peak_next  = peak_max;
                        rr_int_next    = rr_inc;
                        push           = 1'b1;
                        push_val       = peak_max;
                        rr_cnt_next    = '0;
                        ref_cnt_next   = '0;
                        state_next     = REFRAC;
                    end
                end
                REFRAC: begin
                    rr_cnt_next  = rr_inc;
                    ref_cnt_next = ref_cnt_reg + 1'b1;
                    if (ref_cnt_reg == REF_W'(REFRAC_LEN - 1))
                        state_next = DETECT;
                end
                default: state_next = LEARN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= LEARN;
            seg_cnt_reg   <= '0;
            seg_max_reg   <= '0;
            push_cnt_reg  <= '0;
            rr_cnt_reg    <= '0;
            srch_cnt_reg  <= '0;
            ref_cnt_reg   <= '0;
            peak_reg      <= '0;
            qrs_valid_reg <= 1'b0;
            qrs_peak_reg  <= '0;
            rr_int_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            seg_cnt_reg   <= seg_cnt_next;
            seg_max_reg   <= seg_max_next;
            push_cnt_reg  <= push_cnt_next;
            rr_cnt_reg    <= rr_cnt_next;
            srch_cnt_reg  <= srch_cnt_next;
            ref_cnt_reg   <= ref_cnt_next;
            peak_reg      <= peak_next;
            qrs_valid_reg <= qrs_valid_next;
            qrs_peak_reg  <= qrs_peak_next;
            rr_int_reg    <= rr_int_next;
        end
    end

    // Peak history shift: slot 0 is vt1 (newest).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_vt
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst_n)
                        vt_reg[gi] <= '0;
                    else if (push)
                        vt_reg[gi] <= push_val;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst_n)
                        vt_reg[gi] <= '0;
                    else if (push)
                        vt_reg[gi] <= vt_reg[gi-1];
                end
            end
        end
    endgenerate

    assign vt1         = vt_reg[0];
    assign vt2         = vt_reg[1];
    assign vt3         = vt_reg[2];
    assign vt4         = vt_reg[3];
    assign learning    = (state_reg == LEARN);
    assign qrs_valid   = qrs_valid_reg;
    assign qrs_peak    = qrs_peak_reg;
    assign rr_interval = rr_int_reg;

endmodule

// File: tb/tb_qrs_threshold_controller.sv
// Directed bench for qrs_threshold_controller: a vector table for the learning
// phase plus hand-written sequences for beats, RR timing, gaps and resets.
// Two instances share stimulus; the second uses a 4-bit RR counter.
module tb_qrs_threshold_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [15:0] sample;
    logic        thr_out;

    logic [15:0] vt1, vt2, vt3, vt4, qrs_peak;
    logic [31:0] mpavg;
    logic        learning, qrs_valid;
    logic [11:0] rr_interval;

    logic [15:0] s_vt1, s_vt2, s_vt3, s_vt4, s_qrs_peak;
    logic [31:0] s_mpavg;
    logic        s_learning, s_qrs_valid;
    logic [3:0]  s_rr_interval;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qrs_threshold_controller #(
        .W(16), .AVG_LOG2(3), .LEARN_LEN(4), .SEARCH_LEN(4), .REFRAC_LEN(8), .RR_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .thr_out(thr_out), .vt1(vt1), .vt2(vt2), .vt3(vt3), .vt4(vt4),
        .mpavg(mpavg), .learning(learning), .qrs_valid(qrs_valid),
        .qrs_peak(qrs_peak), .rr_interval(rr_interval)
    );

    qrs_threshold_controller #(
        .W(16), .AVG_LOG2(3), .LEARN_LEN(4), .SEARCH_LEN(4), .REFRAC_LEN(8), .RR_W(4)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .thr_out(thr_out), .vt1(s_vt1), .vt2(s_vt2), .vt3(s_vt3), .vt4(s_vt4),
        .mpavg(s_mpavg), .learning(s_learning), .qrs_valid(s_qrs_valid),
        .qrs_peak(s_qrs_peak), .rr_interval(s_rr_interval)
    );

    typedef struct {
        logic [15:0] smp;
        logic        thr;
        logic [31:0] avg;
        logic [15:0] v1;
        logic        lrn;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] s, input logic t, input int gap);
        repeat (gap) @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b1;
        sample       = s;
        thr_out      = t;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        thr_out      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_table(input int maxgap);
        for (int i = 0; i < 16; i++) begin
            strobe(tbl[i].smp, tbl[i].thr, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            $display("vec %0d: sample=%0d thr=%0d mpavg=%0d vt1=%0d learning=%0d",
                     i, tbl[i].smp, tbl[i].thr, mpavg, vt1, learning);
            chk($sformatf("tbl%0d_mpavg", i), mpavg, tbl[i].avg);
            chk($sformatf("tbl%0d_vt1", i), 32'(vt1), 32'(tbl[i].v1));
            chk($sformatf("tbl%0d_learning", i), 32'(learning), 32'(tbl[i].lrn));
            chk($sformatf("tbl%0d_qrs_valid", i), 32'(qrs_valid), 32'd0);
        end
        chk("learn_vt2", 32'(vt2), 32'd30);
        chk("learn_vt3", 32'(vt3), 32'd20);
        chk("learn_vt4", 32'(vt4), 32'd10);
    endtask

    initial begin
        int pulses;
        // Learning table: segments of 4 peaking at 10, 20, 30, 40; thr_out
        // asserted on two strobes to show it is ignored while learning.
        // mpavg = floor(sum of last 8 samples / 8).
        tbl[0]  = '{16'd5,  1'b0, 32'd0,  16'd0,  1'b1};
        tbl[1]  = '{16'd10, 1'b1, 32'd1,  16'd0,  1'b1};
        tbl[2]  = '{16'd3,  1'b0, 32'd2,  16'd0,  1'b1};
        tbl[3]  = '{16'd0,  1'b0, 32'd2,  16'd10, 1'b1};
        tbl[4]  = '{16'd20, 1'b0, 32'd4,  16'd10, 1'b1};
        tbl[5]  = '{16'd1,  1'b0, 32'd4,  16'd10, 1'b1};
        tbl[6]  = '{16'd2,  1'b0, 32'd5,  16'd10, 1'b1};
        tbl[7]  = '{16'd7,  1'b0, 32'd6,  16'd20, 1'b1};
        tbl[8]  = '{16'd9,  1'b1, 32'd6,  16'd20, 1'b1};
        tbl[9]  = '{16'd30, 1'b0, 32'd9,  16'd20, 1'b1};
        tbl[10] = '{16'd30, 1'b0, 32'd12, 16'd20, 1'b1};
        tbl[11] = '{16'd4,  1'b0, 32'd12, 16'd30, 1'b1};
        tbl[12] = '{16'd40, 1'b0, 32'd15, 16'd30, 1'b1};
        tbl[13] = '{16'd0,  1'b0, 32'd15, 16'd30, 1'b1};
        tbl[14] = '{16'd0,  1'b0, 32'd15, 16'd30, 1'b1};
        tbl[15] = '{16'd11, 1'b0, 32'd15, 16'd40, 1'b0};

        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        thr_out      = 1'b0;

        // 1: reset held for 3 clocks with strobes active
        @(negedge clk);
        sample_valid = 1'b1;
        sample       = 16'd123;
        thr_out      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sample_valid = 1'b0;
        thr_out      = 1'b0;
        $display("reset: vt1=%0d mpavg=%0d learning=%0d qrs_valid=%0d", vt1, mpavg, learning, qrs_valid);
        chk("rst_vt1", 32'(vt1), 32'd0);
        chk("rst_vt4", 32'(vt4), 32'd0);
        chk("rst_mpavg", mpavg, 32'd0);
        chk("rst_learning", 32'(learning), 32'd1);
        chk("rst_qrs_valid", 32'(qrs_valid), 32'd0);
        chk("rst_qrs_peak", 32'(qrs_peak), 32'd0);
        chk("rst_rr", 32'(rr_interval), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: mean of constant 80 ramps by 10 per strobe, then a 0 drops it to 70
        for (int k = 1; k <= 8; k++) begin
            strobe(16'd80, 1'b0, 0);
            $display("mean strobe %0d: mpavg=%0d", k, mpavg);
            chk($sformatf("mean_%0d", k), mpavg, 32'(10 * k));
        end
        chk("mean_vt1", 32'(vt1), 32'd80);
        chk("mean_vt2", 32'(vt2), 32'd80);
        strobe(16'd0, 1'b0, 0);
        $display("mean strobe 9: mpavg=%0d", mpavg);
        chk("mean_9", mpavg, 32'd70);

        do_reset();
        #1;
        chk("rst2_mpavg", mpavg, 32'd0);
        chk("rst2_vt1", 32'(vt1), 32'd0);

        // 3: learning table
        run_table(0);

        // 4: single beat; rr counts from DETECT entry
        for (int k = 0; k < 3; k++) begin
            strobe(16'd0, 1'b0, 0);
            chk("det_qrs_valid", 32'(qrs_valid), 32'd0);
        end
        strobe(16'd100, 1'b1, 0);
        chk("trig_qrs_valid", 32'(qrs_valid), 32'd0);
        strobe(16'd500, 1'b1, 0);
        chk("srch1_qrs_valid", 32'(qrs_valid), 32'd0);
        strobe(16'd200, 1'b1, 0);
        chk("srch2_qrs_valid", 32'(qrs_valid), 32'd0);
        strobe(16'd300, 1'b1, 0);
        $display("beat1: qrs_valid=%0d peak=%0d rr=%0d vt=%0d,%0d,%0d,%0d",
                 qrs_valid, qrs_peak, rr_interval, vt1, vt2, vt3, vt4);
        chk("beat1_valid", 32'(qrs_valid), 32'd1);
        chk("beat1_peak", 32'(qrs_peak), 32'd500);
        chk("beat1_rr", 32'(rr_interval), 32'd7);
        chk("beat1_vt1", 32'(vt1), 32'd500);
        chk("beat1_vt2", 32'(vt2), 32'd40);
        chk("beat1_vt3", 32'(vt3), 32'd30);
        chk("beat1_vt4", 32'(vt4), 32'd20);
        @(posedge clk);
        #1;
        chk("beat1_pulse_len", 32'(qrs_valid), 32'd0);
        chk("beat1_peak_hold", 32'(qrs_peak), 32'd500);

        // Refractory with thr_out high: no pulse
        for (int k = 0; k < 8; k++) begin
            strobe(16'd999, 1'b1, 0);
            chk($sformatf("refrac%0d_qrs_valid", k), 32'(qrs_valid), 32'd0);
        end

        // 5/6: second beat 120 strobes after the first trigger, with idle gaps
        // and thr_out held high on idle cycles only.
        pulses = 0;
        for (int k = 0; k < 108; k++) begin
            if (k == 50) begin
                @(negedge clk);
                thr_out = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                thr_out = 1'b0;
            end
            strobe(16'd0, 1'b0, int'($urandom_range(0, 2)));
            if (qrs_valid) pulses++;
        end
        chk("det_gap_pulses", 32'(pulses), 32'd0);
        chk("det_gap_learning", 32'(learning), 32'd0);
        strobe(16'd50, 1'b1, 1);
        strobe(16'd60, 1'b0, 2);
        strobe(16'd70, 1'b0, 0);
        strobe(16'd80, 1'b0, 3);
        $display("beat2: qrs_valid=%0d peak=%0d rr=%0d vt1=%0d vt2=%0d",
                 qrs_valid, qrs_peak, rr_interval, vt1, vt2);
        chk("beat2_valid", 32'(qrs_valid), 32'd1);
        chk("beat2_peak", 32'(qrs_peak), 32'd80);
        chk("beat2_rr", 32'(rr_interval), 32'd120);
        chk("beat2_vt1", 32'(vt1), 32'd80);
        chk("beat2_vt2", 32'(vt2), 32'd500);

        // 6: learning table again with idle gaps -> identical outputs
        do_reset();
        run_table(3);

        // 5: RR_W = 4 -> 15 trigger-free DETECT strobes return to LEARN
        for (int k = 1; k <= 15; k++) begin
            strobe(16'd0, 1'b0, int'($urandom_range(0, 1)));
            $display("rr-sat strobe %0d: learning=%0d", k, s_learning);
            chk($sformatf("rrsat%0d_learning", k), 32'(s_learning), (k == 15) ? 32'd1 : 32'd0);
        end
        chk("wide_rr_learning", 32'(learning), 32'd0);

        // 6: reset in the middle of SEARCH aborts the beat
        strobe(16'd100, 1'b1, 0);
        strobe(16'd900, 1'b0, 0);
        do_reset();
        #1;
        $display("mid-search reset: qrs_valid=%0d learning=%0d vt1=%0d", qrs_valid, learning, vt1);
        chk("abort_learning", 32'(learning), 32'd1);
        chk("abort_vt1", 32'(vt1), 32'd0);
        chk("abort_peak", 32'(qrs_peak), 32'd0);
        for (int k = 0; k < 3; k++) begin
            strobe(16'd900, 1'b0, 0);
            chk($sformatf("abort%0d_qrs_valid", k), 32'(qrs_valid), 32'd0);
            chk($sformatf("abort%0d_learning", k), 32'(learning), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
